gpu_circle_sequencer: RTL

- Command-level controller for gpu_octantdraw: accepts one circle command (centre, radius, colour, octant mask) over a valid/ready handshake.
- Issues up to 8 octant passes to one octantdraw instance, each as a start-level/done sequence.
- Qualifies the drawer's free-running X/Y into a pixel stream with a valid strobe, clips off-screen pixels, and reports completion.
- Sits between the command decoder and the framebuffer write port.

---
 rtl/gpu_circle_sequencer_pkg.sv | 54 +++++
 rtl/gpu_circle_sequencer_next_octant.sv | 37 +++
 rtl/gpu_circle_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_circle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_circle_sequencer_pkg
// Description : Shared definitions for the circle sequencer: screen geometry,
//               field widths, sequencer state encoding and clip counter width.
//               Ports: none (package only).
// Revision    : 1.0 - initial release
// ============================================================================

// Legacy macro view of the screen geometry for code that still uses the
// gpu_definitions header style.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

package gpu_circle_sequencer_pkg;

  localparam int WIDTH        = `WIDTH;
  localparam int HEIGHT       = `HEIGHT;
  localparam int WIDTH_BITS   = `WIDTH_BITS;
  localparam int HEIGHT_BITS  = `HEIGHT_BITS;
  localparam int CHANNEL_BITS = `CHANNEL_BITS;
  localparam int OCT_BITS     = 3;
  localparam int CLIP_BITS    = 16;

  // Clip limits in the drawer's native coordinate widths; a wrapped negative
  // coordinate lands above these limits and is clipped the same way.
  localparam logic [WIDTH_BITS-1:0]  X_LIMIT = WIDTH_BITS'(WIDTH);
  localparam logic [HEIGHT_BITS-1:0] Y_LIMIT = HEIGHT_BITS'(HEIGHT);

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_SELECT = 3'd1,
    SEQ_LAUNCH = 3'd2,
    SEQ_RUN    = 3'd3,
    SEQ_GAP    = 3'd4,
    SEQ_FINISH = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/gpu_circle_sequencer_next_octant.sv
`default_nettype none
// ============================================================================
// Module      : gpu_circle_sequencer_next_octant
// Description : Combinational search for the lowest set octant-mask bit whose
//               index is >= from_i. Used both for the first octant of a
//               command (from_i = 0) and for stepping after each octant
//               (from_i = current + 1, which may be 8 -> nothing found).
// Ports       : mask_i  - 8-bit octant enable mask
//               from_i  - 4-bit lowest index allowed (0..8)
//               idx_o   - selected octant index
//               found_o - high when a qualifying bit exists
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_circle_sequencer_next_octant
  import gpu_circle_sequencer_pkg::*;
(
  input  logic [7:0]          mask_i,
  input  logic [3:0]          from_i,
  output logic [OCT_BITS-1:0] idx_o,
  output logic                found_o
);

  // Scanning downward lets the last hit win, which is the lowest index.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (mask_i[k] && (4'(k) >= from_i)) begin
        idx_o   = OCT_BITS'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpu_circle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gpu_circle_sequencer
// Description : Command-level controller for one octant drawer. Accepts a
//               circle command, runs one start/done pass per enabled octant
//               in ascending order, qualifies the drawer's X/Y into a clipped
//               pixel stream and reports completion.
// Ports       : clk, n_rst (async, active-low)
//               cmd_*_i / cmd_ready_o       - command handshake and fields
//               od_*_o                      - latched command, octant, start
//               od_busy_i/od_done_i/od_x_i/od_y_i - drawer status and point
//               pix_*_o                     - registered pixel stream
//               busy_o, circle_done_o, err_timeout_o, clip_count_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_circle_sequencer
  import gpu_circle_sequencer_pkg::*;
#(
  parameter int LAUNCH_TIMEOUT = 8,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [WIDTH_BITS-1:0]   cmd_xc_i,
  input  logic [HEIGHT_BITS-1:0]  cmd_yc_i,
  input  logic [WIDTH_BITS-1:0]   cmd_rad_i,
  input  logic [CHANNEL_BITS-1:0] cmd_r_i,
  input  logic [CHANNEL_BITS-1:0] cmd_g_i,
  input  logic [CHANNEL_BITS-1:0] cmd_b_i,
  input  logic [7:0]              cmd_oct_mask_i,
  output logic [WIDTH_BITS-1:0]   od_xc_o,
  output logic [HEIGHT_BITS-1:0]  od_yc_o,
  output logic [WIDTH_BITS-1:0]   od_rad_o,
  output logic [CHANNEL_BITS-1:0] od_r_o,
  output logic [CHANNEL_BITS-1:0] od_g_o,
  output logic [CHANNEL_BITS-1:0] od_b_o,
  output logic [OCT_BITS-1:0]     od_oct_o,
  output logic                    od_start_o,
  input  logic                    od_busy_i,
  input  logic                    od_done_i,
  input  logic [WIDTH_BITS-1:0]   od_x_i,
  input  logic [HEIGHT_BITS-1:0]  od_y_i,
  output logic                    pix_valid_o,
  output logic [WIDTH_BITS-1:0]   pix_x_o,
  output logic [HEIGHT_BITS-1:0]  pix_y_o,
  output logic [CHANNEL_BITS-1:0] pix_r_o,
  output logic [CHANNEL_BITS-1:0] pix_g_o,
  output logic [CHANNEL_BITS-1:0] pix_b_o,
  output logic                    busy_o,
  output logic                    circle_done_o,
  output logic                    err_timeout_o,
  output logic [CLIP_BITS-1:0]    clip_count_o
);

  localparam int TW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LAUNCH_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  seq_state_t                state_q;
  logic                      cmd_ready_q;
  logic [WIDTH_BITS-1:0]     xc_q;
  logic [HEIGHT_BITS-1:0]    yc_q;
  logic [WIDTH_BITS-1:0]     rad_q;
  logic [CHANNEL_BITS-1:0]   r_q;
  logic [CHANNEL_BITS-1:0]   g_q;
  logic [CHANNEL_BITS-1:0]   b_q;
  logic [7:0]                mask_q;
  logic [OCT_BITS-1:0]       oct_ptr_q;
  logic [OCT_BITS-1:0]       od_oct_q;
  logic                      od_start_q;
  logic [TW-1:0]             timer_q;
  logic [GW-1:0]             gap_q;
  logic                      busy_q;
  logic                      pix_valid_q;
  logic [WIDTH_BITS-1:0]     pix_x_q;
  logic [HEIGHT_BITS-1:0]    pix_y_q;
  logic [CHANNEL_BITS-1:0]   pix_r_q;
  logic [CHANNEL_BITS-1:0]   pix_g_q;
  logic [CHANNEL_BITS-1:0]   pix_b_q;
  logic                      circle_done_q;
  logic                      err_q;
  logic [CLIP_BITS-1:0]      clip_q;

  // In IDLE the search runs over the incoming mask from bit 0; afterwards it
  // steps over the latched mask strictly above the current octant.
  logic [7:0]                search_mask;
  logic [3:0]                search_from;
  logic [OCT_BITS-1:0]       nxt_idx;
  logic                      nxt_found;

  assign search_mask = (state_q == SEQ_IDLE) ? cmd_oct_mask_i : mask_q;
  assign search_from = (state_q == SEQ_IDLE) ? 4'd0 : ({1'b0, oct_ptr_q} + 4'd1);

  gpu_circle_sequencer_next_octant u_next_octant (
    .mask_i  (search_mask),
    .from_i  (search_from),
    .idx_o   (nxt_idx),
    .found_o (nxt_found)
  );

  // The first busy cycle of a pass still shows the previous X/Y; requiring
  // the delayed busy as well skips it while keeping the final iteration.
  logic raw_valid;
  logic clip_hit;

  assign raw_valid = (state_q == SEQ_RUN) && od_busy_i && busy_q;
  assign clip_hit  = (od_x_i >= X_LIMIT) || (od_y_i >= Y_LIMIT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= SEQ_IDLE;
      cmd_ready_q   <= 1'b0;
      xc_q          <= '0;
      yc_q          <= '0;
      rad_q         <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      mask_q        <= '0;
      oct_ptr_q     <= '0;
      od_oct_q      <= '0;
      od_start_q    <= 1'b0;
      timer_q       <= '0;
      gap_q         <= '0;
      busy_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
      circle_done_q <= 1'b0;
      err_q         <= 1'b0;
      clip_q        <= '0;
    end else begin
      circle_done_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      busy_q        <= 1'b0;

      if (raw_valid) begin
        if (clip_hit) begin
          if (clip_q != '1) begin
            clip_q <= clip_q + CLIP_BITS'(1);
          end
        end else begin
          pix_valid_q <= 1'b1;
          pix_x_q     <= od_x_i;
          pix_y_q     <= od_y_i;
          pix_r_q     <= r_q;
          pix_g_q     <= g_q;
          pix_b_q     <= b_q;
        end
      end

      case (state_q)
        SEQ_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            xc_q        <= cmd_xc_i;
            yc_q        <= cmd_yc_i;
            rad_q       <= cmd_rad_i;
            r_q         <= cmd_r_i;
            g_q         <= cmd_g_i;
            b_q         <= cmd_b_i;
            mask_q      <= cmd_oct_mask_i;
            clip_q      <= '0;
            err_q       <= 1'b0;
            if (nxt_found) begin
              oct_ptr_q <= nxt_idx;
              state_q   <= SEQ_SELECT;
            end else begin
              state_q   <= SEQ_FINISH;
            end
          end
        end

        SEQ_SELECT: begin
          od_oct_q   <= oct_ptr_q;
          od_start_q <= 1'b1;
          timer_q    <= '0;
          state_q    <= SEQ_LAUNCH;
        end

        // od_done is still high from the previous pass here, so only
        // od_busy is trusted as proof the drawer took the start edge.
        SEQ_LAUNCH: begin
          if (od_busy_i) begin
            busy_q  <= 1'b1;
            state_q <= SEQ_RUN;
          end else if (timer_q == TIMER_LAST) begin
            err_q      <= 1'b1;
            od_start_q <= 1'b0;
            state_q    <= SEQ_FINISH;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        SEQ_RUN: begin
          busy_q <= od_busy_i;
          if (!od_busy_i && od_done_i) begin
            busy_q     <= 1'b0;
            od_start_q <= 1'b0;
            gap_q      <= '0;
            state_q    <= SEQ_GAP;
          end
        end

        // Holding od_start low lets the drawer's edge detector re-arm.
        SEQ_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (nxt_found) begin
              oct_ptr_q <= nxt_idx;
              state_q   <= SEQ_SELECT;
            end else begin
              state_q   <= SEQ_FINISH;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        SEQ_FINISH: begin
          circle_done_q <= 1'b1;
          cmd_ready_q   <= 1'b1;
          state_q       <= SEQ_IDLE;
        end

        default: begin
          od_start_q <= 1'b0;
          state_q    <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign od_xc_o       = xc_q;
  assign od_yc_o       = yc_q;
  assign od_rad_o      = rad_q;
  assign od_r_o        = r_q;
  assign od_g_o        = g_q;
  assign od_b_o        = b_q;
  assign od_oct_o      = od_oct_q;
  assign od_start_o    = od_start_q;
  assign pix_valid_o   = pix_valid_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign pix_r_o       = pix_r_q;
  assign pix_g_o       = pix_g_q;
  assign pix_b_o       = pix_b_q;
  assign busy_o        = (state_q != SEQ_IDLE);
  assign circle_done_o = circle_done_q;
  assign err_timeout_o = err_q;
  assign clip_count_o  = clip_q;

endmodule

`default_nettype wire
